// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler and RAW hazard scoreboard for a 1W/2R register file.
// Round-robin arbitration of the RF write port between the ALU and the memory
// unit, a registered write stage, and per-register 2-bit outstanding-write
// counters that drive the issue-stage stall.
module rf_wb_scheduler #(
    parameter int entries       = 4,
    parameter int data_bus_size = 8,
    localparam int AW = $clog2(entries),
    localparam int DW = data_bus_size
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_dst,
    input  logic [1:0][AW-1:0]   issue_src,
    output logic                 issue_stall,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_dst,
    input  logic [DW-1:0]        alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [AW-1:0]        mem_dst,
    input  logic [DW-1:0]        mem_data,
    output logic                 mem_ready,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_dst,
    output logic [DW-1:0]        wr_data,
    output logic                 wb_error
);

    logic [1:0]         pend [entries];
    logic               last;
    logic               issue_accept;
    logic               retire_to_empty;
    logic [entries-1:0] inc_vec;
    logic [entries-1:0] dec_vec;

    // Grants and stall come only from live inputs and registered state;
    // everything is forced low while reset is asserted.
    always_comb begin
        alu_ready   = 1'b0;
        mem_ready   = 1'b0;
        issue_stall = 1'b0;
        if (reset_n) begin
            alu_ready   = alu_valid && (!mem_valid || last);
            mem_ready   = mem_valid && (!alu_valid || !last);
            issue_stall = issue_valid &&
                          ((pend[issue_src[0]] != 2'd0) ||
                           (pend[issue_src[1]] != 2'd0) ||
                           (pend[issue_dst] == 2'd3));
        end
    end

    // Per-register increment/decrement requests for this cycle.
    always_comb begin
        issue_accept    = issue_valid && !issue_stall;
        retire_to_empty = wr_en && (pend[wr_dst] == 2'd0);
        inc_vec         = '0;
        dec_vec         = '0;
        for (int r = 0; r < entries; r++) begin
            inc_vec[r] = issue_accept && (issue_dst == AW'(r));
            dec_vec[r] = wr_en && (wr_dst == AW'(r));
        end
    end

    // Scoreboard counters and the sticky error flag. A decrement on an empty
    // register is absorbed (stays 0) and flagged instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < entries; r++) pend[r] <= 2'd0;
            wb_error <= 1'b0;
        end else begin
            for (int r = 0; r < entries; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    pend[r] <= pend[r] + 2'd1;
                else if (dec_vec[r] && !inc_vec[r] && pend[r] != 2'd0)
                    pend[r] <= pend[r] - 2'd1;
            end
            if (retire_to_empty) wb_error <= 1'b1;
        end
    end

    // Write stage and round-robin pointer; address/data hold when idle.
    // The pointer resets to MEM so the ALU wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_dst  <= '0;
            wr_data <= '0;
            last    <= 1'b1;
        end else begin
            wr_en <= alu_ready || mem_ready;
            if (alu_ready) begin
                wr_dst  <= alu_dst;
                wr_data <= alu_data;
                last    <= 1'b0;
            end else if (mem_ready) begin
                wr_dst  <= mem_dst;
                wr_data <= mem_data;
                last    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the rules.
module tb_rf_wb_scheduler;
    localparam int AW = 2;
    localparam int DW = 8;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               issue_valid;
    logic [AW-1:0]      issue_dst;
    logic [1:0][AW-1:0] issue_src;
    logic               issue_stall;
    logic               alu_valid, mem_valid;
    logic [AW-1:0]      alu_dst, mem_dst;
    logic [DW-1:0]      alu_data, mem_data;
    logic               alu_ready, mem_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_dst;
    logic [DW-1:0]      wr_data;
    logic               wb_error;

    rf_wb_scheduler #(.entries(4), .data_bus_size(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_src(issue_src),
        .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data), .wb_error(wb_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: outstanding-write counts, sticky error, who was
    // granted last, and the contents of the one-deep write stage.
    int m_pend [4];
    bit m_err;
    int m_last;
    bit m_wr_en;
    int m_wr_dst;
    int m_wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset_n     = 1'b1;
        issue_valid = 1'b0;
        issue_dst   = '0;
        issue_src   = '0;
        alu_valid   = 1'b0;
        alu_dst     = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_dst     = '0;
        mem_data    = '0;
    endtask

    task automatic issue(input int dst, input int s0, input int s1);
        issue_valid  = 1'b1;
        issue_dst    = AW'(dst);
        issue_src[0] = AW'(s0);
        issue_src[1] = AW'(s1);
    endtask

    // One clock cycle: inputs are already driven (set at the negedge).
    // Check combinational outputs, advance the model at the edge, then check
    // the registered outputs; returns at the next negedge.
    task automatic cycle();
        bit exp_stall;
        int g;
        bit inc, dec;
        #1;
        exp_stall = reset_n && issue_valid &&
                    (m_pend[issue_src[0]] > 0 || m_pend[issue_src[1]] > 0 || m_pend[issue_dst] >= 3);
        g = -1;
        if (reset_n) begin
            if (alu_valid && mem_valid) g = (m_last == 1) ? 0 : 1;
            else if (alu_valid)         g = 0;
            else if (mem_valid)         g = 1;
        end
        chk("issue_stall", issue_stall, exp_stall);
        chk("alu_ready", alu_ready, g == 0);
        chk("mem_ready", mem_ready, g == 1);
        @(posedge clock);
        if (!reset_n) begin
            foreach (m_pend[r]) m_pend[r] = 0;
            m_err = 0; m_last = 1; m_wr_en = 0; m_wr_dst = 0; m_wr_data = 0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                inc = issue_valid && !exp_stall && (issue_dst == r);
                dec = m_wr_en && (m_wr_dst == r);
                if (dec && m_pend[r] == 0) m_err = 1;
                if (inc && !dec) m_pend[r] = m_pend[r] + 1;
                else if (dec && !inc && m_pend[r] > 0) m_pend[r] = m_pend[r] - 1;
            end
            if (g == 0) begin
                m_wr_en = 1; m_wr_dst = alu_dst; m_wr_data = alu_data; m_last = 0;
            end else if (g == 1) begin
                m_wr_en = 1; m_wr_dst = mem_dst; m_wr_data = mem_data; m_last = 1;
            end else begin
                m_wr_en = 0;
            end
        end
        #1;
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_dst", wr_dst, m_wr_dst);
        chk("wr_data", wr_data, m_wr_data);
        chk("wb_error", wb_error, m_err);
        @(negedge clock);
    endtask

    task automatic idle_cycles(input int n);
        idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        foreach (m_pend[r]) m_pend[r] = 0;
        m_err = 0; m_last = 1; m_wr_en = 0; m_wr_dst = 0; m_wr_data = 0;
        idle();
        @(negedge clock);

        // Reset
        reset_n = 1'b0;
        alu_valid = 1'b1; mem_valid = 1'b1; issue(0, 0, 0);
        #1;
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_stall", issue_stall, 1'b0);
        cycle();
        idle(); reset_n = 1'b0; cycle();
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wb_error", wb_error, 1'b0);

        // Single write to r2 after one pre-issue
        idle(); issue(2, 0, 0); cycle();
        idle(); alu_valid = 1'b1; alu_dst = 2'd2; alu_data = 8'h5A;
        #1 chk("t1_alu_ready", alu_ready, 1'b1);
        cycle();
        chk("t1_wr_en", wr_en, 1'b1);
        chk("t1_wr_dst", wr_dst, 2'd2);
        chk("t1_wr_data", wr_data, 8'h5A);
        idle(); issue(3, 2, 2);
        #1 chk("t1_stall_during_wr", issue_stall, 1'b1);
        idle(); cycle();
        issue(3, 2, 2);
        #1 chk("t1_unstalled", issue_stall, 1'b0);
        idle(); cycle();
        chk("t1_wb_error", wb_error, 1'b0);

        // Tie fairness from a fresh reset
        idle(); reset_n = 1'b0; cycle();
        idle(); issue(1, 0, 0); cycle(); cycle();
        issue(3, 0, 0); cycle(); cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_dst = 2'd1; alu_data = 8'(8'h10 + i);
            mem_valid = 1'b1; mem_dst = 2'd3; mem_data = 8'(8'hC0 + i);
            #1 chk("tie_alu_ready", alu_ready, (i % 2) == 0);
            cycle();
            chk("tie_wr_dst", wr_dst, (i % 2) ? 2'd3 : 2'd1);
        end
        idle_cycles(2);

        // RAW stall on r1
        idle(); issue(1, 0, 0); cycle();
        issue(2, 1, 0);
        #1 chk("raw_stall_0", issue_stall, 1'b1);
        cycle(); cycle();
        alu_valid = 1'b1; alu_dst = 2'd1; alu_data = 8'h77;
        cycle();
        alu_valid = 1'b0;
        #1 chk("raw_stall_wr_cycle", issue_stall, 1'b1);
        chk("raw_wr_data", wr_data, 8'h77);
        cycle();
        #1 chk("raw_unstalled", issue_stall, 1'b0);
        cycle();
        idle(); alu_valid = 1'b1; alu_dst = 2'd2; alu_data = 8'h22; cycle();
        idle_cycles(2);

        // Saturation on r0
        idle(); issue(0, 3, 3); cycle(); cycle(); cycle();
        #1 chk("sat_stall", issue_stall, 1'b1);
        mem_valid = 1'b1; mem_dst = 2'd0; mem_data = 8'h0F;
        cycle();
        mem_valid = 1'b0;
        cycle();
        #1 chk("sat_accept", issue_stall, 1'b0);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_dst = 2'd0; mem_data = 8'(i); cycle();
        end
        idle_cycles(2);

        // Same-cycle issue and retire on r2 keeps the count at 1
        idle(); issue(2, 3, 3); cycle();
        idle(); alu_valid = 1'b1; alu_dst = 2'd2; alu_data = 8'hA2; cycle();
        idle(); issue(2, 3, 3); cycle();
        idle(); issue(0, 2, 2);
        #1 chk("simul_still_pending", issue_stall, 1'b1);
        idle(); alu_valid = 1'b1; alu_dst = 2'd2; alu_data = 8'hB2; cycle();
        idle_cycles(2);
        issue(0, 2, 2);
        #1 chk("simul_drained", issue_stall, 1'b0);
        idle();

        // Retire to empty r3 sets a sticky error
        mem_valid = 1'b1; mem_dst = 2'd3; mem_data = 8'h33; cycle();
        idle(); cycle();
        chk("err_set", wb_error, 1'b1);
        idle_cycles(3);
        chk("err_held", wb_error, 1'b1);

        // Reset mid-operation with pend[1]=2 and MEM requesting
        idle(); issue(1, 0, 0); cycle(); cycle();
        idle(); reset_n = 1'b0; mem_valid = 1'b1; mem_dst = 2'd1; mem_data = 8'hEE;
        cycle();
        chk("midrst_wr_en", wr_en, 1'b0);
        chk("midrst_wb_error", wb_error, 1'b0);
        idle(); issue(2, 1, 1);
        #1 chk("midrst_pend_clear", issue_stall, 1'b0);
        idle();
        alu_valid = 1'b1; mem_valid = 1'b1; alu_dst = 2'd0; mem_dst = 2'd1;
        #1 chk("midrst_tie_alu", alu_ready, 1'b1);
        cycle();
        idle_cycles(2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset_n      = ($urandom_range(0, 49) != 0);
            issue_valid  = $urandom_range(0, 1);
            issue_dst    = AW'($urandom_range(0, 3));
            issue_src[0] = AW'($urandom_range(0, 3));
            issue_src[1] = AW'($urandom_range(0, 3));
            alu_valid    = ($urandom_range(0, 2) == 0);
            alu_dst      = AW'($urandom_range(0, 3));
            alu_data     = DW'($urandom);
            mem_valid    = ($urandom_range(0, 2) == 0);
            mem_dst      = AW'($urandom_range(0, 3));
            mem_data     = DW'($urandom);
            cycle();
        end
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Writeback scheduler and hazard scoreboard for the architectural register file (one write port, two read ports). It arbitrates the single RF write port between two writeback sources (ALU and memory unit) with round-robin fairness. It also tracks outstanding writes per register so the issue stage stalls on read-after-write hazards. It sits between the execute/memory stages and the RF write port, and drives the issue-stage stall.

## Interface
- `entries`, 4: number of RF registers; address width is AW = $clog2(entries).
- `data_bus_size`, 8: data width, DW.
- `clock`  in  1  Single clock; all state updates on posedge.
- `reset_n`  in  1  Reset: synchronous, active-low.
- `issue_valid`  in  1  Issue stage presents an instruction.
- `issue_dst`  in  AW  Destination register of the issuing instruction.
- `issue_src`  in  AW [1:0]  Source registers of the issuing instruction.
- `issue_stall`  out  1  Combinational; issue is not accepted this cycle.
- `alu_valid`, `mem_valid`  in  1  Writeback request from the ALU / memory unit.
- `alu_dst`, `mem_dst`  in  AW  Writeback destination register.
- `alu_data`, `mem_data`  in  DW  Writeback data.
- `alu_ready`, `mem_ready`  out  1  Combinational grant; transfer occurs when valid && ready.
- `wr_en`  out  1  Registered RF write enable.
- `wr_dst`  out  AW  Registered RF write address.
- `wr_data`  out  DW  Registered RF write data.
- `wb_error`  out  1  Sticky flag: a write retired to a register with no outstanding issue.

## Operation
- **Scoreboard**
  - One 2-bit saturating counter `pend[r]` per register. It counts accepted issues minus retired writes.
  - `issue_stall = issue_valid && (pend[issue_src[0]]!=0 || pend[issue_src[1]]!=0 || pend[issue_dst]==3)`.
  - Issue is accepted when `issue_valid && !issue_stall`. An accepted issue increments `pend[issue_dst]`.
  - A retirement is any cycle with `wr_en==1`. It decrements `pend[wr_dst]`.
  - An increment and a decrement on the same register in the same cycle leave it unchanged.
  - A retirement to a register with `pend==0` leaves `pend` at 0 and sets `wb_error`. `wb_error` clears only on reset.
- **Arbitration**
  - A 1-bit pointer `last` records the most recent grant (0 = ALU, 1 = MEM).
  - Only one requester valid: that requester is granted.
  - Both valid: grant ALU if `last==1`, otherwise grant MEM.
  - Neither valid: no grant, and `last` holds.
  - `last` updates on every grant. Ready is never asserted to a requester whose valid is low.
- **Write stage**
  - A granted transfer is captured into `wr_en/wr_dst/wr_data` at the next edge.
  - No grant in a cycle: `wr_en` is 0 the following cycle, and `wr_dst`/`wr_data` hold their last values.
  - The write stage never backpressures, so at most one write retires per cycle.
- **Reset** (`reset_n==0` at posedge)
  - All `pend`, `wr_en`, `wr_dst`, `wr_data` and `wb_error` go to 0. `last` goes to 1, so ALU wins the first tie.
  - While `reset_n` is low, `alu_ready`, `mem_ready` and `issue_stall` are 0.
  - In-flight writes are discarded; a granted transfer in the reset cycle is dropped.

## Timing
- Grant-to-RF-write latency: grant in cycle N, then `wr_en` high in N+1, then the RF holds the data after the N+1 edge.
- The scoreboard decrement happens at the same edge as the RF write. A dependent reader therefore unstalls in N+2 and reads the new value combinationally. No forwarding is provided.
- Issue accepted in cycle N: the dependent read stalls from N+1 onward.
- `issue_stall` and ready depend only on the current inputs and registered state. There is no combinational path from `wr_*`.
- Maximum throughput is one retirement per cycle. Under continuous dual requests, grants alternate ALU, MEM, ALU, ...

## Test plan
- **Reset, then single write:** `alu_valid=1, alu_dst=2, alu_data=0x5A` for one cycle, with `pend[2]=1` pre-issued. Required: `alu_ready=1`, `wr_en=1`, `wr_dst=2`, `wr_data=0x5A` next cycle; `pend[2]` returns to 0; `wb_error=0`.
- **Tie fairness:** both valid for 4 cycles (ALU dst 1 / MEM dst 3, each pre-issued twice). Required: grants ALU, MEM, ALU, MEM; `wr_dst` sequence 1, 3, 1, 3.
- **RAW stall:** issue `dst=1`, then issue `src0=1`. Required: stall asserted until the cycle after `wr_en` with `wr_dst=1`; the source reads the new value once unstalled.
- **Saturation:** issue to `dst=0` three times with no writeback, then a fourth issue. Required: fourth `issue_stall=1`; accepted after one retirement to register 0.
- **Simultaneous events and error:**
  - Same-cycle issue and retire to register 2 with `pend[2]=1`. Required: `pend` stays 1.
  - Retire to register 3 with `pend[3]=0`. Required: `wb_error=1` and it holds.
- **Reset mid-operation:** assert `reset_n=0` while MEM is granted and `pend[1]=2`. Required: next cycle `wr_en=0`, all `pend=0`, `wb_error=0`, and the first subsequent tie grants ALU.
